// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and a saturating stall counter.
module pipe_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_FIELDS     = 5,
  parameter int SKID           = 1,
  parameter int ZERO_ON_BUBBLE = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [NUM_FIELDS*DATA_WIDTH-1:0] i_data,
  input  logic                             i_flush,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [NUM_FIELDS*DATA_WIDTH-1:0] o_data,
  output logic [1:0]                       o_occupancy,
  output logic [CNT_WIDTH-1:0]             o_stall_cnt,
  input  logic                             i_cnt_clr
);

  localparam int W = NUM_FIELDS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         main_q, main_d;
  logic [W-1:0]         skid_q, skid_d;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (i_valid) begin
          main_d  = i_data;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_d = i_data;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end else if (in_xfer && (SKID != 0)) begin
          skid_d  = i_data;
          state_d = ST_SKID_FULL;
        end
      end
      ST_SKID_FULL: begin
        if (i_ready) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush only shapes the next state; a downstream beat leaving now still counts.
    if (i_flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    valid_d = (state_d != ST_EMPTY);
    ready_d = (state_d != ST_SKID_FULL);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (valid_q && !i_ready && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
    end
  end

  generate
    if (SKID != 0) begin : g_ready_reg
      assign o_ready = ready_q;
    end else begin : g_ready_comb
      assign o_ready = ~valid_q | i_ready;
    end
  endgenerate

  // Bubble masking is the only logic allowed between main_q and o_data.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      if (ZERO_ON_BUBBLE != 0) begin : g_mask
        assign o_data[gi*DATA_WIDTH +: DATA_WIDTH] =
          valid_q ? main_q[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_hold
        assign o_data[gi*DATA_WIDTH +: DATA_WIDTH] = main_q[gi*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

  assign o_valid     = valid_q;
  assign o_occupancy = 2'(state_q);
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid/zero-bubble instance (4-bit counter) and a
// single-register/hold-data instance, checked by vector table, sequences and a FIFO model.
module tb_pipe_stage_reg;
  localparam int DW = 32;
  localparam int NF = 5;
  localparam int W  = DW * NF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // dut0: SKID=1, ZERO_ON_BUBBLE=1, CNT_WIDTH=4
  logic v0 = 0, r0 = 0, f0 = 0, c0 = 0;
  logic [W-1:0] d0 = '0;
  logic ov0, ordy0;
  logic [W-1:0] od0;
  logic [1:0] occ0;
  logic [3:0] cnt0;

  // dut1: SKID=0, ZERO_ON_BUBBLE=0, CNT_WIDTH=16
  logic v1 = 0, r1 = 0, f1 = 0, c1 = 0;
  logic [W-1:0] d1 = '0;
  logic ov1, ordy1;
  logic [W-1:0] od1;
  logic [1:0] occ1;
  logic [15:0] cnt1;

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .SKID(1), .ZERO_ON_BUBBLE(1), .CNT_WIDTH(4)) u_dut0 (
    .clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(ordy0), .i_data(d0), .i_flush(f0),
    .o_valid(ov0), .i_ready(r0), .o_data(od0), .o_occupancy(occ0), .o_stall_cnt(cnt0),
    .i_cnt_clr(c0));

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .SKID(0), .ZERO_ON_BUBBLE(0), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(ordy1), .i_data(d1), .i_flush(f1),
    .o_valid(ov1), .i_ready(r1), .o_data(od1), .o_occupancy(occ1), .o_stall_cnt(cnt1),
    .i_cnt_clr(c1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input int k);
    logic [W-1:0] r;
    for (int j = 0; j < NF; j++) r[j*DW +: DW] = 32'(j * 32'h100 + k);
    return r;
  endfunction

  typedef struct {
    logic v, r, f, c;
    logic [W-1:0] d;
    logic ov, ordy;
    logic [1:0] occ;
    logic [W-1:0] od;
    logic [3:0] cnt;
  } vec_t;

  function automatic vec_t row(input logic v, input logic r, input logic f, input logic c,
                               input logic [W-1:0] d, input logic ov, input logic ordy,
                               input logic [1:0] occ, input logic [W-1:0] od, input logic [3:0] cnt);
    vec_t x;
    x.v = v; x.r = r; x.f = f; x.c = c; x.d = d;
    x.ov = ov; x.ordy = ordy; x.occ = occ; x.od = od; x.cnt = cnt;
    return x;
  endfunction

  // Reference model: each stage is a bounded FIFO of beats.
  logic [W-1:0] mdat [2][2];
  int           msz  [2];
  logic [W-1:0] mlast[2];
  int           mcnt [2];

  function automatic int cmax(input int d);
    return (d == 0) ? 15 : 65535;
  endfunction

  function automatic bit mready(input int d, input logic r);
    return (d == 0) ? (msz[d] < 2) : (msz[d] == 0 || r);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      msz[d] = 0; mlast[d] = '0; mcnt[d] = 0;
      mdat[d][0] = '0; mdat[d][1] = '0;
    end
  endtask

  task automatic model_step(input int d, input logic v, input logic r, input logic f,
                            input logic c, input logic [W-1:0] data);
    bit vld, push, pop;
    vld  = msz[d] > 0;
    push = v && mready(d, r);
    pop  = vld && r;
    if (c) mcnt[d] = 0;
    else if (vld && !r && mcnt[d] < cmax(d)) mcnt[d]++;
    if (pop) begin
      mlast[d] = mdat[d][0];
      mdat[d][0] = mdat[d][1];
      msz[d]--;
    end
    if (push) begin
      mdat[d][msz[d]] = data;
      msz[d]++;
    end
    if (f) begin
      msz[d] = 0;
      mlast[d] = '0;
    end
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] x;
    for (int j = 0; j < NF; j++) x[j*DW +: DW] = $urandom;
    return x;
  endfunction

  vec_t tbl[23];

  initial begin
    logic [W-1:0] A, B, C, D, E, F, P, Q, R;
    A = mk(32'hA); B = mk(32'hB); C = mk(32'hC);
    D = mk(32'hD); E = mk(32'hE); F = mk(32'hF);

    // Stream 8 beats with i_ready high, then drain.
    tbl[0] = row(1, 1, 0, 0, mk(0), 0, 1, 0, '0, 0);
    for (int k = 1; k < 8; k++) tbl[k] = row(1, 1, 0, 0, mk(k), 1, 1, 1, mk(k - 1), 0);
    tbl[8]  = row(0, 1, 0, 0, '0, 1, 1, 1, mk(7), 0);
    tbl[9]  = row(0, 1, 0, 0, '0, 0, 1, 0, '0, 0);
    // Stall into skid: A accepted, i_ready low for 3 cycles.
    tbl[10] = row(1, 1, 0, 0, A, 0, 1, 0, '0, 0);
    tbl[11] = row(1, 0, 0, 0, B, 1, 1, 1, A, 0);
    tbl[12] = row(1, 0, 0, 0, C, 1, 0, 2, A, 1);
    tbl[13] = row(1, 0, 0, 0, C, 1, 0, 2, A, 2);
    tbl[14] = row(1, 1, 0, 0, C, 1, 0, 2, A, 3);
    tbl[15] = row(1, 1, 0, 0, C, 1, 1, 1, B, 3);
    tbl[16] = row(0, 1, 0, 0, '0, 1, 1, 1, C, 3);
    tbl[17] = row(0, 1, 0, 0, '0, 0, 1, 0, '0, 3);
    // Flush in SKID_FULL with an incoming beat and downstream stalled.
    tbl[18] = row(1, 0, 0, 0, D, 0, 1, 0, '0, 3);
    tbl[19] = row(1, 0, 0, 0, E, 1, 1, 1, D, 3);
    tbl[20] = row(1, 0, 1, 0, F, 1, 0, 2, D, 4);
    tbl[21] = row(0, 0, 0, 0, '0, 0, 1, 0, '0, 5);
    tbl[22] = row(0, 1, 0, 0, '0, 0, 1, 0, '0, 5);

    // Asynchronous reset mid-cycle while holding a stalled beat.
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    v0 = 1; d0 = mk(32'h77); r0 = 0;
    @(posedge clk); #1;
    v0 = 0;
    @(posedge clk); #1;
    chk("pre_rst_valid", ov0, 1);
    chk("pre_rst_cnt", cnt0, 1);
    #2 rst = 1;
    #1;
    chk("rst_valid", ov0, 0);
    chk("rst_ready", ordy0, 1);
    chk("rst_data", od0, '0);
    chk("rst_occ", occ0, 0);
    chk("rst_cnt", cnt0, 0);
    chk("rst1_valid", ov1, 0);
    chk("rst1_data", od1, '0);
    $display("reset checked mid-cycle");
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 23; i++) begin
      v0 = tbl[i].v; r0 = tbl[i].r; f0 = tbl[i].f; c0 = tbl[i].c; d0 = tbl[i].d;
      #2;
      $display("vec %0d: v=%0b r=%0b fl=%0b ov=%0b rdy=%0b occ=%0d cnt=%0d",
               i, v0, r0, f0, ov0, ordy0, occ0, cnt0);
      chk($sformatf("vec%0d_valid", i), ov0, tbl[i].ov);
      chk($sformatf("vec%0d_ready", i), ordy0, tbl[i].ordy);
      chk($sformatf("vec%0d_occ", i), occ0, tbl[i].occ);
      chk($sformatf("vec%0d_data", i), od0, tbl[i].od);
      chk($sformatf("vec%0d_cnt", i), cnt0, tbl[i].cnt);
      @(posedge clk); #1;
    end
    v0 = 0; r0 = 0; f0 = 0; c0 = 0;

    // Counter saturation and clear during a stall.
    v0 = 1; d0 = mk(32'h55);
    @(posedge clk); #1;
    v0 = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("cnt_sat", cnt0, 15);
    $display("stall counter after 20 stalls = %0d", cnt0);
    c0 = 1;
    @(posedge clk); #1;
    c0 = 0;
    chk("cnt_clr", cnt0, 0);
    @(posedge clk); #1;
    chk("cnt_after_clr", cnt0, 1);
    chk("sat_hold_data", od0, mk(32'h55));
    r0 = 1;
    @(posedge clk); #1;
    r0 = 0;
    chk("sat_drained", ov0, 0);

    // Single-register mode: combinational ready, back-to-back, hold-data bubble.
    P = mk(32'h21); Q = mk(32'h22); R = '0; R[31:0] = 32'hDEAD;
    r1 = 0; #1;
    chk("s0_empty_ready", ordy1, 1);
    v1 = 1; d1 = P;
    @(posedge clk); #1;
    v1 = 0;
    chk("s0_full_valid", ov1, 1);
    chk("s0_full_ready", ordy1, 0);
    chk("s0_full_data", od1, P);
    chk("s0_full_occ", occ1, 1);
    r1 = 1; #1;
    chk("s0_comb_ready", ordy1, 1);
    v1 = 1; d1 = Q;
    @(posedge clk); #1;
    chk("s0_b2b_q", od1, Q);
    chk("s0_b2b_valid", ov1, 1);
    d1 = R;
    @(posedge clk); #1;
    chk("s0_b2b_r", od1, R);
    v1 = 0;
    @(posedge clk); #1;
    chk("s0_drain_valid", ov1, 0);
    chk("s0_drain_hold", od1[31:0], 32'hDEAD);
    chk("s0_drain_occ", occ1, 0);
    $display("single-register drain: valid=%0b field0=%h", ov1, od1[31:0]);
    r1 = 0;

    // Randomised run of both instances against the FIFO model.
    rst = 1;
    #2 rst = 0;
    model_reset();
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0] ed;
      v0 = ($urandom_range(0, 3) != 0); r0 = ($urandom_range(0, 2) != 0);
      f0 = ($urandom_range(0, 31) == 0); c0 = ($urandom_range(0, 63) == 0); d0 = rnd_data();
      v1 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 2) != 0);
      f1 = ($urandom_range(0, 31) == 0); c1 = ($urandom_range(0, 63) == 0); d1 = rnd_data();
      #2;
      ed = (msz[0] > 0) ? mdat[0][0] : '0;
      chk("rnd0_valid", ov0, msz[0] > 0);
      chk("rnd0_ready", ordy0, mready(0, r0));
      chk("rnd0_occ", occ0, msz[0]);
      chk("rnd0_data", od0, ed);
      chk("rnd0_cnt", cnt0, mcnt[0]);
      ed = (msz[1] > 0) ? mdat[1][0] : mlast[1];
      chk("rnd1_valid", ov1, msz[1] > 0);
      chk("rnd1_ready", ordy1, mready(1, r1));
      chk("rnd1_occ", occ1, msz[1]);
      chk("rnd1_data", od1, ed);
      chk("rnd1_cnt", cnt1, mcnt[1]);
      @(posedge clk);
      model_step(0, v0, r0, f0, c0, d0);
      model_step(1, v1, r1, f1, c1, d1);
      #1;
    end
    $display("random run: 400 cycles on both instances");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic, parametrised pipeline-stage register for the CPU datapath, replacing the fixed five-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries NUM_FIELDS packed fields of DATA_WIDTH bits each, using a valid/ready handshake. An optional skid buffer registers the upstream ready path. It supports flush (bubble insertion) and keeps a saturating stall-cycle counter for performance debug.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one field.
- NUM_FIELDS, 5, number of packed fields; field k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- SKID, 1, selects the ready mode.
  - 1: 2-entry skid buffer, o_ready driven from a flop.
  - 0: single register, o_ready combinational.
- ZERO_ON_BUBBLE, 1.
  - 1: o_data is forced to all-zero while o_valid=0, so zero is a NOP to downstream.
  - 0: o_data holds its last value.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- i_rst, in, 1, reset; asynchronous, active-high.
- i_valid, in, 1, upstream beat valid.
- o_ready, out, 1, stage accepts a beat this cycle.
- i_data, in, NUM_FIELDS*DATA_WIDTH, packed upstream fields.
- i_flush, in, 1, synchronous flush: drop all held and incoming beats.
- o_valid, out, 1, downstream beat valid.
- i_ready, in, 1, downstream accepts.
- o_data, out, NUM_FIELDS*DATA_WIDTH, packed output fields.
- o_occupancy, out, 2, number of held beats (0..2; max 1 when SKID=0).
- o_stall_cnt, out, CNT_WIDTH, saturating count of cycles with o_valid=1 and i_ready=0.
- i_cnt_clr, in, 1, synchronous clear of o_stall_cnt.

## Operation
- Handshake and storage:
  - Upstream transfer when i_valid & o_ready; downstream transfer when o_valid & i_ready.
  - Storage is a main register (drives o_data) plus, when SKID=1, one skid register.
- State machine (SKID=1): EMPTY, FULL, SKID_FULL.
  - EMPTY: o_valid=0, o_ready=1. On i_valid: load main, go to FULL.
  - FULL: o_valid=1, o_ready=1.
    - in & out: load main, stay FULL.
    - out only: go to EMPTY.
    - in only: load skid, go to SKID_FULL.
    - neither: hold.
  - SKID_FULL: o_valid=1, o_ready=0. On i_ready: main <= skid, go to FULL. Upstream beats are not accepted in this state.
- SKID=0 mode:
  - States are EMPTY and FULL only; o_ready = ~o_valid | i_ready.
  - In FULL, in & out loads main; out only goes to EMPTY.
- Flush:
  - i_flush has highest priority. Next state is EMPTY and the main and skid registers clear to zero.
  - An upstream beat presented in the flush cycle is dropped, even though o_ready may read 1.
  - A downstream transfer in the flush cycle still completes; flush only affects the following state.
- Ordering: beats leave in arrival order with no loss and no duplication.
- Stall counter:
  - Increments on each cycle with o_valid & ~i_ready and saturates at 2^CNT_WIDTH-1.
  - i_cnt_clr forces it to 0 and overrides the increment in the same cycle.
  - Flush does not affect the counter.

## Timing
- Reset values: o_valid=0, o_ready=1, o_data=0, o_occupancy=0, o_stall_cnt=0; state EMPTY; all storage zero. Reset takes effect immediately, including mid-transfer.
- Latency: a beat accepted at edge N is on o_data with o_valid=1 after edge N. Latency is 1 cycle when no stall is present.
- Throughput: 1 beat per cycle when i_ready stays high, in both modes.
- Ready timing:
  - SKID=1: o_ready has no combinational path from i_ready or i_valid; it changes one cycle after the stall condition.
  - SKID=0: o_ready depends combinationally on i_ready.
- Register-to-output: o_data and o_valid come directly from flops. The only logic on o_data is the ZERO_ON_BUBBLE mask.
- Occupancy reports the state after the last edge: EMPTY=0, FULL=1, SKID_FULL=2.

## Test plan
- Reset and stream (SKID=1, NUM_FIELDS=5):
  - Stimulus: assert i_rst mid-cycle, check all outputs are at reset values. Release, then stream fields {k, 0x100+k, ...} for 8 cycles with i_ready=1.
  - Required: each beat appears 1 cycle later in order; o_ready stays 1; o_stall_cnt=0.
- Stall into skid:
  - Stimulus: stream beats A,B,C with i_ready dropped on the cycle after A is accepted, for 3 cycles.
  - Required: B is captured in skid; o_ready=0 and o_occupancy=2; C is held upstream. When i_ready returns, A, B, C are delivered once each, in order; o_stall_cnt=3.
- Flush priority:
  - Stimulus: in SKID_FULL, assert i_flush with i_valid=1 and i_ready=0.
  - Required: the next cycle shows o_valid=0, o_data=0, o_occupancy=0, o_ready=1. The flushed beats and the incoming beat never appear.
- SKID=0 mode:
  - Stimulus: hold the output in FULL with i_ready=0.
  - Required: o_ready=0 in the same cycle. Raising i_ready gives o_ready=1 combinationally and the stage passes back-to-back beats.
- Counter saturation (CNT_WIDTH=4):
  - Stimulus: stall 20 cycles, then assert i_cnt_clr during an ongoing stall.
  - Required: o_stall_cnt stops at 15, then reads 0 the cycle after the clear.
- ZERO_ON_BUBBLE=0:
  - Stimulus: drain beat 0xDEAD, leaving the stage empty.
  - Required: o_valid=0 while o_data still reads 0xDEAD in field 0. With ZERO_ON_BUBBLE=1, o_data=0 in the same situation.
